imem_boot_loader: RTL and testbench
===================================

// Module: imem_boot_loader
// PURPOSE
//  Serial boot controller for the 1024-word instruction memory.
//  - Takes a byte stream from the UART receiver and assembles it into little-endian 32-bit words.
//  - Writes each word into instruction memory through its write port.
//  - Holds the RISC-V core in reset until the whole image is loaded and its checksum passes.
//  - Sits between uart_rx, instr_mem (write side) and the core reset input.
// PARAMETERS
//  ADDR_W       10       word-address width; memory depth = 2**ADDR_W words
//  MAX_WORDS    1024     largest accepted image length N (must be <= 2**ADDR_W)
//  TIMEOUT_CYC  1000000  idle clk cycles allowed between bytes once a transfer has started
// PORTS
//  clk_i           in   1        system clock; all logic on the rising edge
//  rst_ni          in   1        asynchronous, active-low reset
//  boot_en_i       in   1        1: run the loader after reset; 0: bypass straight to DONE
//  rx_valid_i      in   1        one-cycle strobe; rx_data_i is valid in this cycle
//  rx_data_i       in   8        received byte
//  mem_we_o        out  1        instruction memory write enable, one-cycle pulse
//  mem_addr_o      out  32       byte address of the write, = word_idx << 2
//  mem_wdata_o     out  32       assembled write word
//  core_rst_o      out  1        active-high reset to the core
//  done_o          out  1        image loaded and verified (sticky)
//  err_o           out  1        load failed (sticky until rst_ni)
//  words_loaded_o  out  ADDR_W+1 number of words written so far
// BEHAVIOUR
//  Reset values:
//   - core_rst_o=1; every other output is 0.
//   - All internal counters, the checksum and the FSM state go to 0 / S_IDLE.
//  Stream format:
//   - Byte 1: LEN_LO. Byte 2: LEN_HI. N = {LEN_HI, LEN_LO}.
//   - Next 4*N bytes: payload, little-endian (byte0 -> wdata[7:0]).
//   - Last byte: CSUM = XOR of all 4*N payload bytes.
//  FSM states: S_IDLE, S_LEN_HI, S_DATA, S_CSUM, S_DONE, S_ERR.
//   - S_IDLE: first cycle after reset release. boot_en_i=0 -> S_DONE. Otherwise wait here for the LEN_LO byte -> S_LEN_HI. No timeout in this state.
//   - S_LEN_HI: on a byte, form N. N==0 or N>MAX_WORDS -> S_ERR; otherwise -> S_DATA.
//   - S_DATA: shift each byte into a 32-bit assembly register and XOR it into the checksum. On the 4th byte of a word:
//     - mem_we_o=1 in the next cycle, with mem_addr_o = word_idx<<2 and mem_wdata_o = the assembled word;
//     - word_idx and words_loaded_o increment in that same cycle.
//     - After word N-1 is written -> S_CSUM.
//   - S_CSUM: byte == checksum -> S_DONE; mismatch -> S_ERR.
//   - S_DONE: done_o=1; core_rst_o deasserts on the same clock edge that enters S_DONE. Absorbing; further rx bytes are ignored.
//   - S_ERR: err_o=1, core_rst_o stays 1. Absorbing until rst_ni; rx bytes are ignored. Words already written stay in memory.
//  Timeout:
//   - A counter runs in S_LEN_HI, S_DATA and S_CSUM. It clears on every rx_valid_i.
//   - When it reaches TIMEOUT_CYC -> S_ERR.
//  Other rules:
//   - mem_we_o is never high for more than 1 cycle.
//   - Write addresses are strictly sequential from 0x0 and never wrap; at most N writes.
//   - rx_valid_i outside S_IDLE/S_LEN_HI/S_DATA/S_CSUM has no effect.
//   - Asserting rst_ni mid-transfer immediately returns every output to its reset value; the partial image is abandoned.
//   - The next transfer restarts at address 0.
// TESTING
//  1. boot_en_i=0, release reset -> done_o=1 and core_rst_o=0 two cycles after release; mem_we_o never asserted.
//  2. Send 02 00 | 13 00 00 00 | 6F 00 00 00 | 7C (CSUM = 13^6F) ->
//     - write 0x00000013 @0x0, then 0x0000006F @0x4;
//     - words_loaded_o=2, done_o=1, core_rst_o falls.
//  3. Same stream as 2 with CSUM=0x7D -> both words written; err_o=1; core_rst_o stays 1; done_o=0.
//  4. Length bytes 00 00, and separately 01 04 (N=1025) -> err_o=1 right after the 2nd byte; no writes.
//  5. TIMEOUT_CYC=16; stop after 3 payload bytes -> err_o=1 exactly 16 cycles after the last strobe; no write.
//  6. Pull rst_ni low after word 0 is written, then resend the stream from 2 ->
//     - outputs return to reset values while rst_ni is low;
//     - rewrite starts at 0x0 and the load completes.

Source files
------------

// File: rtl/imem_boot_loader.sv
// Serial boot loader: assembles UART bytes into little-endian words, writes them to
// instruction memory, and releases the core reset only after the image checksum matches.
module imem_boot_loader #(
    parameter int unsigned ADDR_W      = 10,
    parameter int unsigned MAX_WORDS   = 1024,
    parameter int unsigned TIMEOUT_CYC = 1000000
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            boot_en_i,
    input  logic            rx_valid_i,
    input  logic [7:0]      rx_data_i,
    output logic            mem_we_o,
    output logic [31:0]     mem_addr_o,
    output logic [31:0]     mem_wdata_o,
    output logic            core_rst_o,
    output logic            done_o,
    output logic            err_o,
    output logic [ADDR_W:0] words_loaded_o
);

    localparam int unsigned CNT_W = ADDR_W + 1;
    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LEN_HI = 3'd1,
        S_DATA   = 3'd2,
        S_CSUM   = 3'd3,
        S_DONE   = 3'd4,
        S_ERR    = 3'd5
    } state_e;

    state_e            state_q, state_d;
    logic [7:0]        len_lo_q, len_lo_d;
    logic [CNT_W-1:0]  n_q, n_d;
    logic [1:0]        byte_cnt_q, byte_cnt_d;
    logic [31:0]       asm_q, asm_d;
    logic [7:0]        csum_q, csum_d;
    logic [CNT_W-1:0]  word_idx_q, word_idx_d;
    logic [TMO_W-1:0]  tmo_q, tmo_d;
    logic              we_q, we_d;
    logic [31:0]       addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              core_rst_q, core_rst_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    logic [15:0]       len_w;
    logic [31:0]       asm_next;

    // Next-state logic: byte parsing, word assembly, checksum, timeout and output decode
    always_comb begin
        state_d    = state_q;
        len_lo_d   = len_lo_q;
        n_d        = n_q;
        byte_cnt_d = byte_cnt_q;
        asm_d      = asm_q;
        csum_d     = csum_q;
        word_idx_d = word_idx_q;
        tmo_d      = '0;
        we_d       = 1'b0;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        len_w      = {rx_data_i, len_lo_q};
        asm_next   = {rx_data_i, asm_q[31:8]};

        case (state_q)
            S_IDLE: begin
                if (!boot_en_i) begin
                    state_d = S_DONE;
                end else if (rx_valid_i) begin
                    len_lo_d = rx_data_i;
                    state_d  = S_LEN_HI;
                end
            end
            S_LEN_HI: begin
                if (rx_valid_i) begin
                    if (len_w == 16'd0 || 17'(len_w) > 17'(MAX_WORDS)) begin
                        state_d = S_ERR;
                    end else begin
                        n_d     = CNT_W'(len_w);
                        state_d = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (rx_valid_i) begin
                    asm_d      = asm_next;
                    csum_d     = csum_q ^ rx_data_i;
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) begin
                        we_d       = 1'b1;
                        addr_d     = 32'(word_idx_q) << 2;
                        wdata_d    = asm_next;
                        word_idx_d = word_idx_q + CNT_W'(1);
                        if (word_idx_d == n_q) begin
                            state_d = S_CSUM;
                        end
                    end
                end
            end
            S_CSUM: begin
                if (rx_valid_i) begin
                    state_d = (rx_data_i == csum_q) ? S_DONE : S_ERR;
                end
            end
            default: ;
        endcase

        // Inter-byte idle watchdog, only while a transfer is in flight
        if (state_q inside {S_LEN_HI, S_DATA, S_CSUM} && !rx_valid_i) begin
            tmo_d = tmo_q + TMO_W'(1);
            if (tmo_d == TMO_W'(TIMEOUT_CYC)) begin
                state_d = S_ERR;
            end
        end

        core_rst_d = (state_d != S_DONE);
        done_d     = (state_d == S_DONE);
        err_d      = (state_d == S_ERR);
    end

    // State and output registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= S_IDLE;
            len_lo_q   <= '0;
            n_q        <= '0;
            byte_cnt_q <= '0;
            asm_q      <= '0;
            csum_q     <= '0;
            word_idx_q <= '0;
            tmo_q      <= '0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            core_rst_q <= 1'b1;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            len_lo_q   <= len_lo_d;
            n_q        <= n_d;
            byte_cnt_q <= byte_cnt_d;
            asm_q      <= asm_d;
            csum_q     <= csum_d;
            word_idx_q <= word_idx_d;
            tmo_q      <= tmo_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            core_rst_q <= core_rst_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    assign mem_we_o       = we_q;
    assign mem_addr_o     = addr_q;
    assign mem_wdata_o    = wdata_q;
    assign core_rst_o     = core_rst_q;
    assign done_o         = done_q;
    assign err_o          = err_q;
    assign words_loaded_o = word_idx_q;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Bench for imem_boot_loader: directed scenarios plus randomized images against a stream-level model.
module tb_imem_boot_loader;

    localparam int unsigned ADDR_W    = 10;
    localparam int unsigned MAX_WORDS = 1024;
    localparam int unsigned TMO       = 16;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            boot_en;
    logic            rx_valid;
    logic [7:0]      rx_data;
    logic            mem_we;
    logic [31:0]     mem_addr;
    logic [31:0]     mem_wdata;
    logic            core_rst;
    logic            done;
    logic            err;
    logic [ADDR_W:0] words_loaded;

    imem_boot_loader #(
        .ADDR_W     (ADDR_W),
        .MAX_WORDS  (MAX_WORDS),
        .TIMEOUT_CYC(TMO)
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .boot_en_i     (boot_en),
        .rx_valid_i    (rx_valid),
        .rx_data_i     (rx_data),
        .mem_we_o      (mem_we),
        .mem_addr_o    (mem_addr),
        .mem_wdata_o   (mem_wdata),
        .core_rst_o    (core_rst),
        .done_o        (done),
        .err_o         (err),
        .words_loaded_o(words_loaded)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        int          cnt;
    } wr_t;

    int          vectors = 0;
    int          fails   = 0;
    wr_t         exp_q[$];
    logic [7:0]  tx_q[$];
    logic [31:0] img_q[$];
    logic        prev_we = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Write-port monitor: every write must match the next expected (addr, data, count)
    always @(negedge clk) begin
        if (rst_n === 1'b1 && mem_we === 1'b1) begin
            wr_t e;
            check("we_single_cycle", 32'(prev_we), 32'd0);
            vectors++;
            assert (exp_q.size() > 0) else begin
                fails++;
                $error("FAIL unexpected_write observed addr=%0h expected no write", mem_addr);
            end
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("wr_addr", mem_addr, e.addr);
                check("wr_data", mem_wdata, e.data);
                check("wr_count", 32'(words_loaded), 32'(e.cnt));
            end
        end
        prev_we = mem_we;
    end

    task automatic do_reset(input logic en);
        @(negedge clk);
        rst_n    = 1'b0;
        boot_en  = en;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        #1;
        check("rst_we", 32'(mem_we), 32'd0);
        check("rst_addr", mem_addr, 32'd0);
        check("rst_wdata", mem_wdata, 32'd0);
        check("rst_core_rst", 32'(core_rst), 32'd1);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_words", 32'(words_loaded), 32'd0);
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Build the byte stream and expected writes for img_q; checksum byte XORed with csum_xor
    task automatic build_stream(input logic [7:0] csum_xor);
        logic [7:0] cs;
        int         n;
        cs = 8'h00;
        n  = img_q.size();
        tx_q.delete();
        tx_q.push_back(8'(n));
        tx_q.push_back(8'(n >> 8));
        for (int i = 0; i < n; i++) begin
            exp_q.push_back('{32'(i) << 2, img_q[i], i + 1});
            for (int b = 0; b < 4; b++) begin
                tx_q.push_back(img_q[i][8*b +: 8]);
                cs = cs ^ img_q[i][8*b +: 8];
            end
        end
        tx_q.push_back(cs ^ csum_xor);
    endtask

    task automatic send_tx(input int gmin, input int gmax);
        while (tx_q.size() > 0) begin
            rx_data  = tx_q.pop_front();
            rx_valid = 1'b1;
            @(negedge clk);
            rx_valid = 1'b0;
            repeat ($urandom_range(gmax, gmin)) @(negedge clk);
        end
    endtask

    task automatic finish_load(input string tag, input int n, input bit bad);
        repeat (3) @(negedge clk);
        check({tag, "_done"}, 32'(done), bad ? 32'd0 : 32'd1);
        check({tag, "_err"}, 32'(err), bad ? 32'd1 : 32'd0);
        check({tag, "_core_rst"}, 32'(core_rst), bad ? 32'd1 : 32'd0);
        check({tag, "_words"}, 32'(words_loaded), 32'(n));
        check({tag, "_pending_writes"}, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic len_error(input logic [7:0] lo, input logic [7:0] hi);
        do_reset(1'b1);
        tx_q.delete();
        tx_q.push_back(lo);
        tx_q.push_back(hi);
        send_tx(0, 0);
        check("len_err_err", 32'(err), 32'd1);
        check("len_err_done", 32'(done), 32'd0);
        check("len_err_core_rst", 32'(core_rst), 32'd1);
        tx_q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        send_tx(0, 1);
        check("len_err_words", 32'(words_loaded), 32'd0);
        check("len_err_sticky", 32'(err), 32'd1);
    endtask

    initial begin
        rst_n    = 1'b0;
        boot_en  = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;

        // Bypass: boot disabled goes straight to done, no writes, rx ignored
        do_reset(1'b0);
        check("byp_done_at_release", 32'(done), 32'd0);
        @(negedge clk);
        @(negedge clk);
        check("byp_done", 32'(done), 32'd1);
        check("byp_core_rst", 32'(core_rst), 32'd0);
        tx_q = '{8'h01, 8'h00, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h00};
        send_tx(0, 0);
        check("byp_words", 32'(words_loaded), 32'd0);
        check("byp_err", 32'(err), 32'd0);

        // Two-word image with correct checksum 0x7C
        do_reset(1'b1);
        img_q = '{32'h0000_0013, 32'h0000_006F};
        build_stream(8'h00);
        check("t2_csum_byte", 32'(tx_q[tx_q.size()-1]), 32'h7C);
        send_tx(0, 0);
        finish_load("t2", 2, 1'b0);
        tx_q = '{8'h01, 8'h00, 8'h12, 8'h34, 8'h56, 8'h78};
        send_tx(0, 0);
        check("t2_ignore_words", 32'(words_loaded), 32'd2);
        check("t2_ignore_done", 32'(done), 32'd1);

        // Same image, checksum 0x7D: words land, load fails
        do_reset(1'b1);
        build_stream(8'h01);
        send_tx(0, 0);
        finish_load("t3", 2, 1'b1);

        // Illegal lengths
        len_error(8'h00, 8'h00);
        len_error(8'h01, 8'h04);

        // Timeout 16 cycles after the third payload byte
        do_reset(1'b1);
        build_stream(8'h00);
        exp_q.delete();
        while (tx_q.size() > 5) void'(tx_q.pop_back());
        send_tx(0, 0);
        check("tmo_err_0", 32'(err), 32'd0);
        for (int m = 1; m < int'(TMO); m++) begin
            @(negedge clk);
            check("tmo_early", 32'(err), 32'd0);
        end
        @(negedge clk);
        check("tmo_err", 32'(err), 32'd1);
        check("tmo_words", 32'(words_loaded), 32'd0);
        check("tmo_core_rst", 32'(core_rst), 32'd1);

        // Gaps one cycle short of the timeout still complete
        do_reset(1'b1);
        img_q = '{32'hDEAD_BEEF};
        build_stream(8'h00);
        send_tx(int'(TMO) - 1, int'(TMO) - 1);
        finish_load("gap_max", 1, 1'b0);

        // Reset mid-transfer after word 0, then reload from address 0
        do_reset(1'b1);
        img_q = '{32'h0000_0013, 32'h0000_006F};
        build_stream(8'h00);
        while (tx_q.size() > 6) void'(tx_q.pop_back());
        send_tx(0, 0);
        @(negedge clk);
        @(negedge clk);
        check("t6_words_mid", 32'(words_loaded), 32'd1);
        check("t6_pending_mid", 32'(exp_q.size()), 32'd1);
        do_reset(1'b1);
        build_stream(8'h00);
        send_tx(0, 0);
        finish_load("t6", 2, 1'b0);

        // Largest legal image
        do_reset(1'b1);
        img_q.delete();
        for (int i = 0; i < int'(MAX_WORDS); i++) img_q.push_back($urandom);
        build_stream(8'h00);
        send_tx(0, 0);
        finish_load("max_len", int'(MAX_WORDS), 1'b0);

        // Randomized images, some with corrupted checksum
        for (int it = 0; it < 12; it++) begin
            int         n;
            bit         bad;
            logic [7:0] x;
            n   = int'($urandom_range(8, 1));
            bad = ($urandom_range(3, 0) == 0);
            x   = bad ? 8'($urandom_range(255, 1)) : 8'h00;
            do_reset(1'b1);
            img_q.delete();
            for (int i = 0; i < n; i++) img_q.push_back($urandom);
            build_stream(x);
            send_tx(0, 4);
            finish_load("rnd", n, bad);
        end

        // Randomized oversize lengths
        for (int it = 0; it < 3; it++) begin
            logic [15:0] n16;
            n16 = 16'($urandom_range(65535, MAX_WORDS + 1));
            len_error(n16[7:0], n16[15:8]);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
